// File: rtl/ram_btn_writer.sv
// Button-driven RAM writer: three buttons edit a data word and an address, and a
// commit writes the word to the data RAM, reads it back and checks it.
module ram_btn_writer #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int RD_LAT = 2,
    parameter logic [AW-1:0] INIT_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    btn,
    input  logic [DW-1:0] q,
    output logic [AW-1:0] address,
    output logic [DW-1:0] data,
    output logic          wren,
    output logic          busy,
    output logic          err,
    output logic [15:0]   wr_count
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT,
        CHECK,
        ERR
    } state_t;

    state_t        state;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    sync3;
    logic [2:0]    btn_edge;
    logic [CW-1:0] wait_cnt;

    // Synchronizer stages reset high so a button held through reset never looks
    // like a fresh press; the edge is registered once more before the FSM uses it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 3'b111;
            sync2    <= 3'b111;
            sync3    <= 3'b111;
            btn_edge <= 3'b000;
            state    <= IDLE;
            address  <= INIT_ADDR;
            data     <= '0;
            wren     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            wr_count <= 16'd0;
            wait_cnt <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            sync3    <= sync2;
            btn_edge <= sync2 & ~sync3;

            case (state)
                IDLE: begin
                    // Commit wins over address step, which wins over data step.
                    if (btn_edge[1]) begin
                        state <= WRITE;
                        wren  <= 1'b1;
                        busy  <= 1'b1;
                    end else if (btn_edge[2]) begin
                        address <= address + AW'(1);
                    end else if (btn_edge[0]) begin
                        data <= data + DW'(1);
                    end
                end
                WRITE: begin
                    wren     <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                CHECK: begin
                    busy <= 1'b0;
                    if (q == data) begin
                        wr_count <= wr_count + 16'd1;
                        address  <= address + AW'(1);
                        state    <= IDLE;
                    end else begin
                        err   <= 1'b1;
                        state <= ERR;
                    end
                end
                ERR: begin
                    wren <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    wren  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_btn_writer.sv
// Directed bench for ram_btn_writer: a vector table of button presses plus
// hand-written sequences for readback errors, wraparound and reset mid-write.
module tb_ram_btn_writer;

    localparam logic [15:0] INIT = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  btn = 3'b000;
    logic [31:0] q;
    logic [15:0] address;
    logic [31:0] data;
    logic        wren, busy, err;
    logic [15:0] wr_count;

    logic [3:0]  q2;
    logic [3:0]  address2;
    logic [3:0]  data2;
    logic        wren2, busy2, err2;
    logic [15:0] wr_count2;

    logic        corrupt = 1'b0;
    logic [31:0] mem [0:65535];
    logic [15:0] rd_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_btn_writer #(.AW(16), .DW(32), .RD_LAT(2), .INIT_ADDR(INIT)) dut (
        .clk(clk), .rst(rst), .btn(btn), .q(q),
        .address(address), .data(data), .wren(wren), .busy(busy),
        .err(err), .wr_count(wr_count)
    );

    // Narrow instance so the data word can be walked all the way round.
    ram_btn_writer #(.AW(4), .DW(4), .RD_LAT(2), .INIT_ADDR(4'h0)) dut_w (
        .clk(clk), .rst(rst), .btn(btn), .q(q2),
        .address(address2), .data(data2), .wren(wren2), .busy(busy2),
        .err(err2), .wr_count(wr_count2)
    );

    assign q2 = data2;

    // Two-clock RAM: registered address, registered q.
    always @(posedge clk) begin
        if (wren) mem[address] <= data;
        rd_addr <= address;
        q <= corrupt ? (mem[rd_addr] ^ 32'h1) : mem[rd_addr];
    end

    typedef struct {
        logic [2:0]  b;
        logic [15:0] expAddr;
        logic [31:0] expData;
        logic [15:0] expCount;
        int          expBusy;
        int          expWren;
        logic [15:0] expWrAddr;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Press for two clocks, release, and watch the outputs for the whole window.
    task automatic applyStimulus(input logic [2:0] b, output int busyCyc, output int wrenCyc,
                                 output logic [15:0] wrA, output logic [31:0] wrD);
        busyCyc = 0;
        wrenCyc = 0;
        wrA = '0;
        wrD = '0;
        @(negedge clk);
        btn = b;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 1) btn = 3'b000;
            if (busy) busyCyc++;
            if (wren) begin
                wrenCyc++;
                wrA = address;
                wrD = data;
            end
        end
    endtask

    vec_t vecs [8];
    int bc, wc;
    logic [15:0] wa;
    logic [31:0] wd;
    bit seen;
    bit sawBad;

    initial begin
        vecs[0] = '{3'b001, INIT,     32'd1, 16'd0, 0, 0, 16'h0000};
        vecs[1] = '{3'b001, INIT,     32'd2, 16'd0, 0, 0, 16'h0000};
        vecs[2] = '{3'b001, INIT,     32'd3, 16'd0, 0, 0, 16'h0000};
        vecs[3] = '{3'b100, 16'hFFFF, 32'd3, 16'd0, 0, 0, 16'h0000};
        vecs[4] = '{3'b010, 16'h0000, 32'd3, 16'd1, 4, 1, 16'hFFFF};
        vecs[5] = '{3'b111, 16'h0001, 32'd3, 16'd2, 4, 1, 16'h0000};
        vecs[6] = '{3'b101, 16'h0002, 32'd3, 16'd2, 0, 0, 16'h0000};
        vecs[7] = '{3'b001, 16'h0002, 32'd4, 16'd2, 0, 0, 16'h0000};

        applyReset();
        checkOutput("reset_address", address, INIT);
        checkOutput("reset_data", data, 0);
        checkOutput("reset_wren", wren, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_wr_count", wr_count, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].b, bc, wc, wa, wd);
            checkOutput($sformatf("vec%0d_address", i), address, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d_data", i), data, vecs[i].expData);
            checkOutput($sformatf("vec%0d_wr_count", i), wr_count, vecs[i].expCount);
            checkOutput($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].expBusy);
            checkOutput($sformatf("vec%0d_wren_cycles", i), wc, vecs[i].expWren);
            checkOutput($sformatf("vec%0d_err", i), err, 0);
            if (vecs[i].expWren != 0) begin
                checkOutput($sformatf("vec%0d_wr_addr", i), wa, vecs[i].expWrAddr);
                checkOutput($sformatf("vec%0d_wr_data", i), wd, vecs[i].expData);
            end
        end

        // Corrupted readback latches err and freezes the block until reset.
        corrupt = 1'b1;
        applyStimulus(3'b010, bc, wc, wa, wd);
        checkOutput("corrupt_err", err, 1);
        checkOutput("corrupt_busy", busy, 0);
        checkOutput("corrupt_address", address, 16'h0002);
        checkOutput("corrupt_wr_count", wr_count, 2);
        checkOutput("corrupt_wren_cycles", wc, 1);
        applyStimulus(3'b001, bc, wc, wa, wd);
        applyStimulus(3'b100, bc, wc, wa, wd);
        applyStimulus(3'b010, bc, wc, wa, wd);
        checkOutput("err_hold_data", data, 4);
        checkOutput("err_hold_address", address, 16'h0002);
        checkOutput("err_hold_wren_cycles", wc, 0);
        checkOutput("err_hold_busy_cycles", bc, 0);
        checkOutput("err_hold_err", err, 1);
        corrupt = 1'b0;
        applyReset();
        checkOutput("err_cleared", err, 0);
        checkOutput("err_reset_address", address, INIT);

        // Walk the narrow data word round its full range.
        for (int i = 0; i < 15; i++) applyStimulus(3'b001, bc, wc, wa, wd);
        checkOutput("narrow_data_max", data2, 4'hF);
        applyStimulus(3'b001, bc, wc, wa, wd);
        checkOutput("narrow_data_wrap", data2, 4'h0);
        applyReset();

        // Reset during WAIT aborts the write; a commit held across reset is ignored.
        @(negedge clk);
        btn = 3'b010;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        checkOutput("wait_busy_seen", seen, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_wren", wren, 0);
        checkOutput("midrst_address", address, INIT);
        checkOutput("midrst_wr_count", wr_count, 0);
        rst = 1'b0;
        sawBad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy || wren) sawBad = 1'b1;
        end
        btn = 3'b000;
        repeat (6) @(negedge clk);
        checkOutput("held_no_commit", sawBad, 0);
        checkOutput("held_address", address, INIT);
        checkOutput("held_wr_count", wr_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
